rv_stage_arb2: RTL

Two-input arbiter that shares one downstream ready-valid pipeline stage between two upstream producers, e.g. instruction fetch and LSU contending for a common memory-request stage in the rv64 core. It holds a one-entry output register with the same valid/allow_in handshake as every other pipeline stage. Grants are round-robin. A burst from one source stays locked until its last beat. A flush input clears in-flight state.

---
 rtl/rv_stage_arb2_if.sv | 76 +++++++
 rtl/rv_stage_arb2.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rv_stage_arb2_if.sv
// ---------------------------------------------------------------------------
// rv_stage_arb2_if
//
// Purpose:
//   Groups every handshake and payload signal of the two-input stage arbiter
//   into one bundle. Signal names follow the arbiter's point of view:
//   i_* are driven by the environment, o_* are driven by the arbiter.
//
// Signals:
//   i_a_valid / i_a_bus / i_a_last   source A beat, payload and burst-end flag
//   o_a_allow_in                     arbiter takes an A beat this cycle
//   i_b_valid / i_b_bus / i_b_last   source B beat, payload and burst-end flag
//   o_b_allow_in                     arbiter takes a B beat this cycle
//   o_out_valid / o_out_bus          registered beat and its payload
//   o_out_src / o_out_last           registered beat's source (0=A, 1=B), last
//   i_out_allow_in                   downstream stage accepts the held beat
//
// Modports:
//   slave  - used by the arbiter itself
//   master - used by whatever drives the producers and the downstream stage
// ---------------------------------------------------------------------------
interface rv_stage_arb2_if #(
    parameter int DW = 64
);

    logic          i_a_valid;
    logic [DW-1:0] i_a_bus;
    logic          i_a_last;
    logic          o_a_allow_in;

    logic          i_b_valid;
    logic [DW-1:0] i_b_bus;
    logic          i_b_last;
    logic          o_b_allow_in;

    logic          o_out_valid;
    logic [DW-1:0] o_out_bus;
    logic          o_out_src;
    logic          o_out_last;
    logic          i_out_allow_in;

    // The arbiter's side of the bundle.
    modport slave (
        input  i_a_valid,
        input  i_a_bus,
        input  i_a_last,
        output o_a_allow_in,
        input  i_b_valid,
        input  i_b_bus,
        input  i_b_last,
        output o_b_allow_in,
        output o_out_valid,
        output o_out_bus,
        output o_out_src,
        output o_out_last,
        input  i_out_allow_in
    );

    // The environment's side: both producers plus the downstream stage.
    modport master (
        output i_a_valid,
        output i_a_bus,
        output i_a_last,
        input  o_a_allow_in,
        output i_b_valid,
        output i_b_bus,
        output i_b_last,
        input  o_b_allow_in,
        input  o_out_valid,
        input  o_out_bus,
        input  o_out_src,
        input  o_out_last,
        output i_out_allow_in
    );

endinterface

// File: rtl/rv_stage_arb2.sv
// ---------------------------------------------------------------------------
// rv_stage_arb2
//
// Purpose:
//   Shares one downstream ready-valid pipeline stage between two upstream
//   producers (for example instruction fetch and the LSU competing for the
//   common memory-request stage). A one-entry output register uses the same
//   valid/allow_in handshake as every other pipeline stage. Single beats are
//   granted round-robin; a multi-beat burst keeps ownership of the stage until
//   its last beat has been accepted. A flush drops the held beat and any lock.
//
// Ports:
//   clk      clock
//   reset    synchronous, active-high reset (wins over flush)
//   i_flush  pipeline flush: clears the output register valid and burst lock
//   bus      rv_stage_arb2_if.slave bundle (sources A/B and output stage)
//
// Parameters:
//   DW       payload width of each request bus
// ---------------------------------------------------------------------------
module rv_stage_arb2 #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_flush,
    rv_stage_arb2_if.slave bus
);

    // IDLE arbitrates round-robin; LOCK_x means source x is mid-burst and
    // owns the stage until it delivers a beat flagged last.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_A = 2'd1,
        ST_LOCK_B = 2'd2
    } arbState_t;

    arbState_t     r_state;
    arbState_t     w_stateNext;

    // Round-robin pointer: 0 means A is preferred, 1 means B is preferred.
    logic          r_prio;
    logic          w_prioNext;

    // One-entry output pipeline register.
    logic          r_outValid;
    logic [DW-1:0] r_outBus;
    logic          r_outSrc;
    logic          r_outLast;

    logic          w_regAllow;
    logic          w_aAllow;
    logic          w_bAllow;
    logic          w_acceptA;
    logic          w_acceptB;

    // The output register can take a new beat when it is empty or when its
    // current beat leaves this cycle. This is a plain pipeline register, so a
    // stall downstream immediately stalls both producers.
    assign w_regAllow = !r_outValid || bus.i_out_allow_in;

    // Grant logic. Each source's allow looks only at the other source's
    // valid, never at its own, which keeps allow_in free of any combinational
    // path from a producer's valid back to its own allow. In IDLE a source is
    // blocked only when the other one is also asking and holds priority; in a
    // lock the owner alone is allowed. A flush blocks everyone for the cycle.
    always_comb begin
        w_aAllow = 1'b0;
        w_bAllow = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_aAllow = w_regAllow && !i_flush && !(bus.i_b_valid && r_prio);
                w_bAllow = w_regAllow && !i_flush && !(bus.i_a_valid && !r_prio);
            end
            ST_LOCK_A: begin
                w_aAllow = w_regAllow && !i_flush;
            end
            ST_LOCK_B: begin
                w_bAllow = w_regAllow && !i_flush;
            end
            default: begin
                w_aAllow = 1'b0;
                w_bAllow = 1'b0;
            end
        endcase
    end

    assign w_acceptA = bus.i_a_valid && w_aAllow;
    assign w_acceptB = bus.i_b_valid && w_bAllow;

    // Next-state and next-priority logic. A beat that does not end its burst
    // locks the stage to its source; a last beat returns to IDLE and hands
    // priority to the other source. Priority is left alone on non-last beats
    // so a burst counts as a single grant for fairness. The grant logic
    // already guarantees at most one accept per cycle.
    always_comb begin
        w_stateNext = r_state;
        w_prioNext  = r_prio;
        if (w_acceptA) begin
            if (bus.i_a_last) begin
                w_stateNext = ST_IDLE;
                w_prioNext  = 1'b1;
            end else begin
                w_stateNext = ST_LOCK_A;
            end
        end else if (w_acceptB) begin
            if (bus.i_b_last) begin
                w_stateNext = ST_IDLE;
                w_prioNext  = 1'b0;
            end else begin
                w_stateNext = ST_LOCK_B;
            end
        end
    end

    // Arbitration state register. Reset clears the pointer as well; flush
    // only drops the lock, so fairness history survives a pipeline flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_prio  <= 1'b0;
        end else if (i_flush) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
            r_prio  <= w_prioNext;
        end
    end

    // Output pipeline register. An accepted beat loads payload, source and
    // last flag. If the register was free to move but nothing arrived it
    // empties; if the downstream stage stalled it keeps its contents. A flush
    // only invalidates the entry, the stale payload is harmless once valid
    // is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outValid <= 1'b0;
            r_outBus   <= '0;
            r_outSrc   <= 1'b0;
            r_outLast  <= 1'b0;
        end else if (i_flush) begin
            r_outValid <= 1'b0;
        end else if (w_acceptA) begin
            r_outValid <= 1'b1;
            r_outBus   <= bus.i_a_bus;
            r_outSrc   <= 1'b0;
            r_outLast  <= bus.i_a_last;
        end else if (w_acceptB) begin
            r_outValid <= 1'b1;
            r_outBus   <= bus.i_b_bus;
            r_outSrc   <= 1'b1;
            r_outLast  <= bus.i_b_last;
        end else if (w_regAllow) begin
            r_outValid <= 1'b0;
        end
    end

    assign bus.o_a_allow_in = w_aAllow;
    assign bus.o_b_allow_in = w_bAllow;
    assign bus.o_out_valid  = r_outValid;
    assign bus.o_out_bus    = r_outBus;
    assign bus.o_out_src    = r_outSrc;
    assign bus.o_out_last   = r_outLast;

endmodule
